// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one Wishbone classic cycle per operation, formatted load data, completion strobes.
// Optional bus timeout is compiled in when LSU_TIMEOUT_EN is defined (limit set by TIMEOUT_CYCLES).
module mem_access_unit
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdat_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        kill_i,
    output logic [31:0] mem_dat_o,
    output logic [4:0]  mem_rd_o,
    output logic        mem_ack_o,
    output logic        mem_exc_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        stall_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

    state_t      state_reg, state_next;
    logic        misaligned, accept, reject, bus_end, bus_fail, kill_any, timeout;
    logic [3:0]  sel_next;
    logic [31:0] wdat_next, lane_data, load_fmt;

    logic [31:0] dat_reg, adr_reg, wdat_reg;
    logic [4:0]  rd_reg;
    logic [3:0]  sel_reg;
    logic [1:0]  size_reg, off_reg;
    logic        ack_reg, exc_reg, mis_reg, berr_reg, we_reg, cyc_reg, uns_reg, kill_reg;

    always_comb begin
        case (mem_size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_addr_i[0];
            2'b10:   misaligned = |mem_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the slave can pick any byte lane by wb_sel_o.
    always_comb begin
        sel_next  = 4'b1111;
        wdat_next = mem_wdat_i;
        case (mem_size_i)
            2'b00: begin
                sel_next  = 4'b0001 << mem_addr_i[1:0];
                wdat_next = {4{mem_wdat_i[7:0]}};
            end
            2'b01: begin
                sel_next  = 4'b0011 << mem_addr_i[1:0];
                wdat_next = {2{mem_wdat_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_data = wb_dat_i >> {off_reg, 3'b000};
        case (size_reg)
            2'b00:   load_fmt = {{24{~uns_reg & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_fmt = {{16{~uns_reg & lane_data[15]}}, lane_data[15:0]};
            default: load_fmt = lane_data;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_reg;

    // The counter holds its BUS-cycle index; the last allowed cycle is TIMEOUT_CYCLES-1.
    assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (state_reg != BUS) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign bus_fail = wb_err_i | (timeout & ~wb_ack_i);
    assign kill_any = kill_reg | kill_i;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        bus_end    = 1'b0;
        stall_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                stall_o = mem_req_i & ~kill_i;
                if (mem_req_i && !kill_i) begin
                    accept     = ~misaligned;
                    reject     = misaligned;
                    state_next = misaligned ? DONE : BUS;
                end
            end
            BUS: begin
                stall_o = mem_req_i;
                if (wb_ack_i || wb_err_i || timeout) begin
                    bus_end    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Keep stall low while reset is held so every output reads zero.
        stall_o = stall_o & rst_ni;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            dat_reg   <= '0;
            adr_reg   <= '0;
            wdat_reg  <= '0;
            rd_reg    <= '0;
            sel_reg   <= '0;
            size_reg  <= '0;
            off_reg   <= '0;
            ack_reg   <= 1'b0;
            exc_reg   <= 1'b0;
            mis_reg   <= 1'b0;
            berr_reg  <= 1'b0;
            we_reg    <= 1'b0;
            cyc_reg   <= 1'b0;
            uns_reg   <= 1'b0;
            kill_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= 1'b0;
            exc_reg   <= 1'b0;
            if (accept) begin
                adr_reg  <= {mem_addr_i[31:2], 2'b00};
                sel_reg  <= sel_next;
                wdat_reg <= wdat_next;
                we_reg   <= mem_we_i;
                cyc_reg  <= 1'b1;
                size_reg <= mem_size_i;
                off_reg  <= mem_addr_i[1:0];
                uns_reg  <= mem_unsigned_i;
                rd_reg   <= mem_we_i ? 5'd0 : mem_rd_i;
                mis_reg  <= 1'b0;
                berr_reg <= 1'b0;
                if (mem_we_i) begin
                    dat_reg <= '0;
                end
            end
            if (reject) begin
                rd_reg   <= mem_we_i ? 5'd0 : mem_rd_i;
                mis_reg  <= 1'b1;
                berr_reg <= 1'b0;
                exc_reg  <= 1'b1;
            end
            if (state_reg == BUS && kill_i) begin
                kill_reg <= 1'b1;
            end
            // A killed operation still finishes its bus cycle; only the strobes are withheld.
            if (bus_end) begin
                cyc_reg  <= 1'b0;
                berr_reg <= bus_fail;
                ack_reg  <= ~bus_fail & ~kill_any;
                exc_reg  <= bus_fail & ~kill_any;
                if (!bus_fail && !we_reg) begin
                    dat_reg <= load_fmt;
                end
            end
            if (state_reg == DONE) begin
                kill_reg <= 1'b0;
            end
        end
    end

    assign mem_dat_o    = dat_reg;
    assign mem_rd_o     = rd_reg;
    assign mem_ack_o    = ack_reg;
    assign mem_exc_o    = exc_reg;
    assign misaligned_o = mis_reg;
    assign bus_err_o    = berr_reg;
    assign wb_adr_o     = adr_reg;
    assign wb_dat_o     = wdat_reg;
    assign wb_sel_o     = sel_reg;
    assign wb_we_o      = we_reg;
    assign wb_cyc_o     = cyc_reg;
    assign wb_stb_o     = cyc_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: randomized operations against a spec-level reference model.
// Defining LSU_TIMEOUT_EN also builds the DUT with TIMEOUT_CYCLES = 4 and runs the timeout case.
module tb_mem_access_unit;
`ifdef LSU_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_req_i = 1'b0, mem_we_i = 1'b0, mem_unsigned_i = 1'b0, kill_i = 1'b0;
    logic [1:0]  mem_size_i = 2'b00;
    logic [31:0] mem_addr_i = '0, mem_wdat_i = '0, wb_dat_i = '0;
    logic [4:0]  mem_rd_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic [31:0] mem_dat_o, wb_adr_o, wb_dat_o;
    logic [4:0]  mem_rd_o;
    logic [3:0]  wb_sel_o;
    logic        mem_ack_o, mem_exc_o, misaligned_o, bus_err_o, stall_o, wb_we_o, wb_cyc_o, wb_stb_o;

`ifdef LSU_TIMEOUT_EN
    mem_access_unit #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i),
        .mem_wdat_i(mem_wdat_i), .mem_rd_i(mem_rd_i), .kill_i(kill_i), .mem_dat_o(mem_dat_o),
        .mem_rd_o(mem_rd_o), .mem_ack_o(mem_ack_o), .mem_exc_o(mem_exc_o), .misaligned_o(misaligned_o),
        .bus_err_o(bus_err_o), .stall_o(stall_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );
`else
    mem_access_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i),
        .mem_wdat_i(mem_wdat_i), .mem_rd_i(mem_rd_i), .kill_i(kill_i), .mem_dat_o(mem_dat_o),
        .mem_rd_o(mem_rd_o), .mem_ack_o(mem_ack_o), .mem_exc_o(mem_exc_o), .misaligned_o(misaligned_o),
        .bus_err_o(bus_err_o), .stall_o(stall_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );
`endif

    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        bit          exc;
        bit          mis;
        bit          berr;
        bit          is_load;
        logic [31:0] dat;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic bit ref_mis(input int size, input logic [31:0] addr);
        return (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] ref_sel(input int size, input int k);
        int m;
        m = (size == 0) ? 1 : (size == 1) ? 3 : 15;
        return 4'(m << k);
    endfunction

    function automatic logic [31:0] ref_wdat(input int size, input logic [31:0] w);
        if (size == 0) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] bus, input int size, input int k, input bit uns);
        logic [31:0] v;
        if (size == 0) begin
            v = (bus >> (8 * k)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (size == 1) begin
            v = (bus >> (8 * k)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
        end else begin
            v = bus;
        end
        return v;
    endfunction

    // Issues one operation (called at posedge+1), acts as the Wishbone slave, ends at posedge+1 after DONE.
    // waits >= 100 means the slave never responds.
    task automatic do_op(input bit we, input int size, input bit uns, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic [4:0] rd, input int waits,
                         input int err_mode, input bit kill_en, input logic [31:0] bus_data);
        bit   mis, to, done, saw_cyc;
        int   k, n, bus_idx, stall_n, exp_stall;
        exp_t e;
        mis = ref_mis(size, addr);
        to  = (waits >= 100);
        k   = int'(addr[1:0]);
        mem_req_i = 1'b1; mem_we_i = we; mem_size_i = 2'(size); mem_unsigned_i = uns;
        mem_addr_i = addr; mem_wdat_i = wdat; mem_rd_i = rd;
        n = cyc_cnt;
        e.mis     = mis;
        e.berr    = !mis && (to || err_mode != 0);
        e.exc     = mis || e.berr;
        e.is_load = !we;
        e.dat     = we ? 32'h0 : ref_load(bus_data, size, k, uns);
        e.rd      = we ? 5'd0 : rd;
        e.cyc     = mis ? n + 1 : to ? n + 1 + TO_CYC : n + 2 + waits;
        exp_stall = mis ? 1 : to ? TO_CYC + 1 : waits + 2;
        if (!kill_en) exp_q.push_back(e);
        $display("[%0d] issue we=%0b size=%0d uns=%0b addr=%h wdat=%h rd=%0d waits=%0d err=%0d kill=%0b",
                 n, we, size, uns, addr, wdat, rd, waits, err_mode, kill_en);
        done = 0; saw_cyc = 0; bus_idx = 0; stall_n = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk_i);
            if (stall_o) stall_n++; else done = 1;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
            if (wb_cyc_o) begin
                if (!saw_cyc) begin
                    chk("bus_adr", wb_adr_o, {addr[31:2], 2'b00});
                    chk("bus_sel", wb_sel_o, ref_sel(size, k));
                    chk("bus_we", wb_we_o, we);
                    chk("bus_stb", wb_stb_o, 1'b1);
                    if (we) chk("bus_wdat", wb_dat_o, ref_wdat(size, wdat));
                end
                saw_cyc = 1;
                kill_i = kill_en && bus_idx == 0;
                if (!to && bus_idx == waits) begin
                    wb_dat_i = bus_data;
                    wb_ack_i = (err_mode != 1);
                    wb_err_i = (err_mode != 0);
                end
                bus_idx++;
            end else begin
                kill_i = 1'b0;
            end
        end
        if (!done) chk("op_completion_bound", 1'b0, 1'b1);
        chk("stall_cycles", stall_n, exp_stall);
        chk("bus_cycle_issued", saw_cyc, !mis);
        @(posedge clk_i); #1;
        mem_req_i = 1'b0; mem_addr_i = $urandom; mem_wdat_i = $urandom; kill_i = 1'b0;
    endtask

    // Monitor: pops one expectation per completion strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (mem_ack_o || mem_exc_o) begin
                $display("[%0d] done ack=%0b exc=%0b mis=%0b berr=%0b rd=%0d dat=%h",
                         cyc_cnt, mem_ack_o, mem_exc_o, misaligned_o, bus_err_o, mem_rd_o, mem_dat_o);
                chk("strobe_exclusive", mem_ack_o & mem_exc_o, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc_cnt, e.cyc);
                    chk("exc_strobe", mem_exc_o, e.exc);
                    chk("ack_strobe", mem_ack_o, !e.exc);
                    if (e.exc) begin
                        chk("misaligned_cause", misaligned_o, e.mis);
                        chk("bus_err_cause", bus_err_o, e.berr);
                    end else begin
                        chk("load_rd", mem_rd_o, e.rd);
                        chk("load_data", mem_dat_o, e.dat);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit    we, uns, kill_en, mis;
        int    size, waits, err_mode, r;
        logic [31:0] addr;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h104;
        repeat (3) @(negedge clk_i);
        chk("reset_outputs_zero",
            {mem_dat_o, mem_rd_o, mem_ack_o, mem_exc_o, misaligned_o, bus_err_o, stall_o,
             wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o}, 128'd0);
        mem_req_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        do_op(0, 0, 0, 32'h103, 32'h0, 5'd7, 0, 0, 0, 32'h80FF_1234);
        do_op(0, 1, 1, 32'h102, 32'h0, 5'd9, 3, 0, 0, 32'h80FF_1234);
        do_op(1, 0, 0, 32'h201, 32'hAB, 5'd3, 0, 0, 0, 32'h0);
        do_op(0, 2, 0, 32'h002, 32'h0, 5'd4, 0, 0, 0, 32'h0);
        do_op(1, 2, 0, 32'h300, 32'h1234_5678, 5'd5, 1, 2, 0, 32'h0);
        do_op(1, 2, 0, 32'h304, 32'hCAFE_F00D, 5'd6, 2, 0, 1, 32'h0);
        do_op(0, 2, 0, 32'h308, 32'h0, 5'd10, 0, 1, 0, 32'hDEAD_BEEF);

        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h400;
        mem_wdat_i = 32'h5555_AAAA; mem_rd_i = 5'd1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_test_in_bus", wb_cyc_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1 chk("rst_mid_bus_outputs_zero",
               {mem_dat_o, mem_rd_o, mem_ack_o, mem_exc_o, misaligned_o, bus_err_o, stall_o,
                wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o}, 128'd0);
        mem_req_i = 1'b0;
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

`ifdef LSU_TIMEOUT_EN
        do_op(0, 2, 0, 32'h500, 32'h0, 5'd11, 1000, 0, 0, 32'h0);
`endif

        for (int i = 0; i < 150; i++) begin
            we       = 1'($urandom_range(0, 1));
            uns      = 1'($urandom_range(0, 1));
            size     = $urandom_range(0, 3);
            addr     = $urandom & 32'h0000_0FFF;
            mis      = ref_mis(size, addr);
            waits    = $urandom_range(0, 3);
            r        = $urandom_range(0, 9);
            err_mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            kill_en  = !mis && ($urandom_range(0, 7) == 0);
            do_op(we, size, uns, addr, $urandom, 5'($urandom_range(1, 31)), waits, err_mode, kill_en, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_i); #1;
            end
        end

        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
